// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM byte-RAM arbiter.
// Width codes, FSM states and the access-length helper.
package mem_arbiter_pkg;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  // width code 3 is served as a full word
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    unique case (w)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle of the arbiter.
// slave = arbiter side, master = pipeline/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_width;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              if_stall;
  logic              mem_stall;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_width,
    input  mem_addr, mem_wdata, ram_din,
    output if_done, if_data,
    output mem_done, mem_rdata,
    output ram_addr, ram_wr, ram_dout,
    output if_stall, mem_stall
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_width,
    output mem_addr, mem_wdata, ram_din,
    input  if_done, if_data,
    input  mem_done, mem_rdata,
    input  ram_addr, ram_wr, ram_dout,
    input  if_stall, mem_stall
  );
endinterface

// File: rtl/mem_arbiter_byte_asm.sv
// Little-endian read assembler: inserts one RAM byte per capture
// at the next byte lane; cleared at the start of each access.
module mem_arbiter_byte_asm (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  input  logic        clr_in,
  input  logic        cap_in,
  input  logic [7:0]  din_in,
  output logic [31:0] word_nxt
);
  import mem_arbiter_pkg::*;

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_nxt = shreg_q;
    word_nxt[{idx_q, 3'b000} +: 8] = din_in;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (clr_in) begin
      shreg_d = ZERO_WORD;
      idx_d   = 2'd0;
    end else if (cap_in) begin
      shreg_d = word_nxt;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg_q <= ZERO_WORD;
      idx_q   <= 2'd0;
    end else if (en_in) begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM between IF and MEM,
// splitting 1/2/4-byte accesses into byte transfers.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  mem_arbiter_if.slave bus
);
  import mem_arbiter_pkg::*;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              is_if_q, is_if_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              asm_clr, asm_cap;
  logic [31:0]       asm_word;
  logic [1:0]        nxt_idx;

  mem_arbiter_byte_asm u_asm (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (rdy_in),
    .clr_in   (asm_clr),
    .cap_in   (asm_cap),
    .din_in   (bus.ram_din),
    .word_nxt (asm_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    is_if_d     = is_if_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    asm_clr     = 1'b0;
    asm_cap     = 1'b0;
    nxt_idx     = cnt_q[1:0] + 2'd1;
    unique case (state_q)
      IDLE: begin
        // MEM holds the older instruction, so it wins
        if (bus.mem_req) begin
          is_if_d    = 1'b0;
          len_d      = width_bytes(bus.mem_width);
          wdata_d    = bus.mem_wdata;
          ram_addr_d = bus.mem_addr;
          cnt_d      = 3'd0;
          asm_clr    = 1'b1;
          if (bus.mem_we) begin
            state_d    = WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end else if (bus.if_req) begin
          is_if_d    = 1'b1;
          len_d      = 3'd4;
          ram_addr_d = bus.if_addr;
          cnt_d      = 3'd0;
          asm_clr    = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        if (is_if_q && !bus.if_req) begin
          state_d = IDLE;
          asm_clr = 1'b1;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          asm_cap = (cnt_q != 3'd0);
          if (cnt_q < len_q - 3'd1)
            ram_addr_d = ram_addr_q + 1'b1;
          if (cnt_q == len_q) begin
            state_d = DONE;
            if (is_if_q) begin
              if_data_d = asm_word;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = asm_word;
              mem_done_d  = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        if (cnt_q == len_q - 3'd1) begin
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          ram_addr_d = ram_addr_q + 1'b1;
          ram_dout_d = wdata_q[{nxt_idx, 3'b000} +: 8];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      is_if_q     <= 1'b0;
      wdata_q     <= ZERO_WORD;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= ZERO_WORD;
      mem_rdata_q <= ZERO_WORD;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      is_if_q     <= is_if_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // gate the strobe so a frozen cycle never repeats a write
  assign bus.ram_wr    = ram_wr_q & rdy_in;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_stall  = bus.if_req & ~if_done_q;
  assign bus.mem_stall = bus.mem_req & ~mem_done_q;

endmodule
